// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, branch and data-memory wait events.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_ex_memread,
  input  logic [4:0]  id_ex_rd,
  input  logic [4:0]  if_id_rs1,
  input  logic [4:0]  if_id_rs2,
  input  logic        branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        ex_mem_write,
  output logic        stall_active,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_t;
  typedef enum logic [1:0] {M_NORM, M_STALL, M_BRANCH, M_WAIT} mode_t;

  localparam logic [3:0]  LOAD_CNT_INIT = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_VAL   = 16'(MEM_TIMEOUT);

  state_t      state, state_nxt;
  mode_t       mode;
  logic [3:0]  load_cnt, load_cnt_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;
  logic        luh, mem_wait;

  assign luh = id_ex_memread && (id_ex_rd != 5'd0) &&
               ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
  assign mem_wait = dmem_req && !dmem_ready;

  always_comb begin
    state_nxt    = state;
    load_cnt_nxt = load_cnt;
    wait_cnt_nxt = wait_cnt;
    mode         = M_NORM;
    case (state)
      RUN: begin
        if (mem_wait) begin
          mode         = M_WAIT;
          wait_cnt_nxt = 16'd1;
          state_nxt    = MEM_WAIT;
        end else if (branch_taken) begin
          mode = M_BRANCH;
        end else if (luh) begin
          mode = M_STALL;
          if (LOAD_STALL_CYCLES > 1) begin
            load_cnt_nxt = LOAD_CNT_INIT;
            state_nxt    = LOAD_STALL;
          end
        end
      end
      LOAD_STALL: begin
        // A memory wait freezes the remaining load stall; it resumes after ready.
        if (mem_wait) begin
          mode         = M_WAIT;
          wait_cnt_nxt = 16'd1;
          state_nxt    = MEM_WAIT;
        end else if (branch_taken) begin
          mode         = M_BRANCH;
          load_cnt_nxt = 4'd0;
          state_nxt    = RUN;
        end else begin
          mode         = M_STALL;
          load_cnt_nxt = load_cnt - 4'd1;
          if (load_cnt <= 4'd1) state_nxt = RUN;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          mode = M_WAIT;
          if (wait_cnt < TIMEOUT_VAL) wait_cnt_nxt = wait_cnt + 16'd1;
        end else begin
          wait_cnt_nxt = 16'd0;
          if (branch_taken) mode = M_BRANCH;
          else if (luh)     mode = M_STALL;
          if (load_cnt != 4'd0) begin
            state_nxt = LOAD_STALL;
          end else begin
            state_nxt = RUN;
            if (!branch_taken && luh && LOAD_STALL_CYCLES > 1) begin
              load_cnt_nxt = LOAD_CNT_INIT;
              state_nxt    = LOAD_STALL;
            end
          end
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_write = 1'b1;
    if (!reset) begin
      case (mode)
        M_STALL: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
        M_BRANCH: begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end
        M_WAIT: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          ex_mem_write = 1'b0;
        end
        default: ;
      endcase
    end
    stall_active = !pc_write;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      load_cnt    <= 4'd0;
      wait_cnt    <= 16'd0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      load_cnt <= load_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (wait_cnt_nxt == TIMEOUT_VAL) mem_timeout <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= 32'd0;
      flush_count  <= 32'd0;
    end else begin
      if (stall_active) stall_cycles <= stall_cycles + 32'd1;
      if (if_id_flush)  flush_count  <= flush_count + 32'd1;
    end
  end
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (1-cycle load stall / 3-cycle load stall with short timeout)
// share stimulus; expected control vectors go through a scoreboard queue.
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // control vector order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write, stall_active}
  localparam logic [5:0] NRM = 6'b110010;
  localparam logic [5:0] STL = 6'b000111;
  localparam logic [5:0] BRN = 6'b111110;
  localparam logic [5:0] WAT = 6'b000001;

  typedef struct {
    logic       memread;
    logic [4:0] rd, rs1, rs2;
    logic       br, req, rdy;
  } in_t;

  typedef struct {
    in_t        i;
    logic [5:0] e;
  } vec_t;

  typedef struct {
    string      nm;
    logic [5:0] a, b;
    bit         cb;
  } exp_t;

  logic clk = 1'b0, reset = 1'b1;
  logic id_ex_memread = 1'b0, branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
  logic [4:0] id_ex_rd = '0, if_id_rs1 = '0, if_id_rs2 = '0;

  logic pcw_a, ifw_a, fl_a, bub_a, exw_a, st_a, to_a;
  logic pcw_b, ifw_b, fl_b, bub_b, exw_b, st_b, to_b;
  logic [31:0] sc_a, fc_a, sc_b, fc_b;
  logic [5:0] ctrl_a, ctrl_b;

  int checks = 0, errors = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(255)) dut_a (
    .clk(clk), .reset(reset), .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_write(pcw_a), .if_id_write(ifw_a),
    .if_id_flush(fl_a), .id_ex_bubble(bub_a), .ex_mem_write(exw_a), .stall_active(st_a),
    .mem_timeout(to_a), .stall_cycles(sc_a), .flush_count(fc_a));

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(4)) dut_b (
    .clk(clk), .reset(reset), .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_write(pcw_b), .if_id_write(ifw_b),
    .if_id_flush(fl_b), .id_ex_bubble(bub_b), .ex_mem_write(exw_b), .stall_active(st_b),
    .mem_timeout(to_b), .stall_cycles(sc_b), .flush_count(fc_b));

  assign ctrl_a = {pcw_a, ifw_a, fl_a, bub_a, exw_a, st_a};
  assign ctrl_b = {pcw_b, ifw_b, fl_b, bub_b, exw_b, st_b};

  function automatic in_t mk(logic m, logic [4:0] rd, logic [4:0] r1, logic [4:0] r2,
                             logic br, logic rq, logic ry);
    in_t v;
    v.memread = m; v.rd = rd; v.rs1 = r1; v.rs2 = r2; v.br = br; v.req = rq; v.rdy = ry;
    return v;
  endfunction

  task automatic apply(input in_t v);
    id_ex_memread = v.memread; id_ex_rd = v.rd; if_id_rs1 = v.rs1; if_id_rs2 = v.rs2;
    branch_taken = v.br; dmem_req = v.req; dmem_ready = v.rdy;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_pop();
    exp_t e;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: queue empty");
      return;
    end
    e = sbq.pop_front();
    chk({e.nm, "_a"}, 32'(ctrl_a), 32'(e.a));
    if (e.cb) chk({e.nm, "_b"}, 32'(ctrl_b), 32'(e.b));
  endtask

  // drive after the edge, compare on the falling edge, advance to just past the next edge
  task automatic cyc(input in_t v, input logic [5:0] ea, input logic [5:0] eb, input bit cb,
                     input string nm);
    exp_t e;
    apply(v);
    e.nm = nm; e.a = ea; e.b = eb; e.cb = cb;
    sbq.push_back(e);
    @(negedge clk);
    check_pop();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input in_t v);
    reset = 1'b1;
    cyc(v, NRM, NRM, 1'b1, "reset_force");
    reset = 1'b0;
  endtask

  in_t IDLE, LUH, BRLUH, BR, WAIT, RDY;
  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    IDLE  = mk(0, 0, 0, 0, 0, 0, 0);
    LUH   = mk(1, 5, 0, 5, 0, 0, 0);
    BRLUH = mk(1, 5, 0, 5, 1, 0, 0);
    BR    = mk(0, 0, 0, 0, 1, 0, 0);
    WAIT  = mk(0, 0, 0, 0, 0, 1, 0);
    RDY   = mk(0, 0, 0, 0, 0, 1, 1);

    tbl.push_back('{IDLE, NRM});
    tbl.push_back('{LUH, STL});
    tbl.push_back('{IDLE, NRM});
    tbl.push_back('{mk(1, 0, 0, 0, 0, 0, 0), NRM});
    tbl.push_back('{mk(0, 7, 7, 0, 0, 0, 0), NRM});
    tbl.push_back('{mk(1, 9, 9, 3, 0, 0, 0), STL});
    tbl.push_back('{mk(1, 9, 8, 3, 0, 0, 0), NRM});
    tbl.push_back('{BRLUH, BRN});
    tbl.push_back('{IDLE, NRM});
    tbl.push_back('{WAIT, WAT});
    tbl.push_back('{WAIT, WAT});
    tbl.push_back('{WAIT, WAT});
    tbl.push_back('{WAIT, WAT});
    tbl.push_back('{RDY, NRM});
    tbl.push_back('{IDLE, NRM});
    tbl.push_back('{mk(0, 0, 0, 0, 1, 1, 0), WAT});
    tbl.push_back('{mk(0, 0, 0, 0, 1, 0, 0), WAT});
    tbl.push_back('{mk(0, 0, 0, 0, 1, 1, 1), BRN});
    tbl.push_back('{RDY, NRM});
    tbl.push_back('{mk(1, 5, 0, 5, 0, 1, 0), WAT});
    tbl.push_back('{mk(1, 5, 0, 5, 0, 1, 1), STL});
    tbl.push_back('{IDLE, NRM});

    // reset forces the enables even with hazard and wait inputs present
    @(posedge clk); #1;
    do_reset(mk(1, 5, 0, 5, 0, 1, 0));
    chk("rst_timeout_a", 32'(to_a), 32'd0);
    chk("rst_stall_cycles_b", sc_b, 32'd0);
    chk("rst_flush_count_b", fc_b, 32'd0);

    for (int k = 0; k < tbl.size(); k++)
      cyc(tbl[k].i, tbl[k].e, 6'b0, 1'b0, $sformatf("tbl%0d", k));
    chk("tbl_timeout_a", 32'(to_a), 32'd0);

    // 3-cycle load stall from a single hazard cycle
    do_reset(IDLE);
    cyc(LUH,  STL, STL, 1'b1, "ls3_c1");
    cyc(IDLE, NRM, STL, 1'b1, "ls3_c2");
    cyc(IDLE, NRM, STL, 1'b1, "ls3_c3");
    cyc(IDLE, NRM, NRM, 1'b1, "ls3_c4");
    chk("ls3_stall_cycles_b", sc_b, PERF ? 32'd3 : 32'd0);
    chk("ls3_stall_cycles_a", sc_a, PERF ? 32'd1 : 32'd0);

    // branch wins over a simultaneous load-use hazard
    do_reset(IDLE);
    cyc(BRLUH, BRN, BRN, 1'b1, "brluh_c1");
    cyc(IDLE,  NRM, NRM, 1'b1, "brluh_c2");
    chk("brluh_flush_count_b", fc_b, PERF ? 32'd1 : 32'd0);
    chk("brluh_stall_cycles_b", sc_b, 32'd0);

    // branch aborts a running load stall
    do_reset(IDLE);
    cyc(LUH,  STL, STL, 1'b1, "abort_c1");
    cyc(BR,   BRN, BRN, 1'b1, "abort_c2");
    cyc(IDLE, NRM, NRM, 1'b1, "abort_c3");

    // memory wait inside a load stall; stall resumes with 2 cycles left
    do_reset(IDLE);
    cyc(LUH,  STL, STL, 1'b1, "resume_c1");
    cyc(WAIT, WAT, WAT, 1'b1, "resume_c2");
    cyc(RDY,  NRM, NRM, 1'b1, "resume_c3");
    cyc(IDLE, NRM, STL, 1'b1, "resume_c4");
    cyc(IDLE, NRM, STL, 1'b1, "resume_c5");
    cyc(IDLE, NRM, NRM, 1'b1, "resume_c6");

    // timeout: dut_b (MEM_TIMEOUT=4) trips after 4 wait cycles, dut_a never does
    do_reset(IDLE);
    for (int k = 1; k <= 10; k++) begin
      cyc(WAIT, WAT, WAT, 1'b1, $sformatf("to_wait%0d", k));
      chk($sformatf("to_flag_b_%0d", k), 32'(to_b), (k >= 4) ? 32'd1 : 32'd0);
    end
    chk("to_flag_a", 32'(to_a), 32'd0);
    do_reset(IDLE);
    chk("to_after_reset_b", 32'(to_b), 32'd0);
    cyc(LUH, STL, STL, 1'b1, "to_run_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
